mult_controller: RTL and testbench
==================================

# mult_controller

Sequencing FSM for the sum-and-shift multiplier datapath. On a start request it clears and loads the datapath registers, then runs `size` test/add/shift iterations driven by the multiplier LSB, and finally raises a one-cycle `done`. It sits beside the operand/accumulator registers and the adder, and drives their `enable` and `clear` inputs.

## Interface
- `size`, 8, operand width in bits; number of iterations per multiplication (≥2)
- `clk`  input  1  clock, all logic on rising edge
- `reset`  input  1  synchronous, active-high reset
- `start`  input  1  request a multiplication; sampled only in IDLE
- `q0`  input  1  current LSB of multiplier register (from datapath)
- `clear`  output  1  active-low clear to accumulator/operand registers
- `load_en`  output  1  enable for operand registers (load A, B)
- `add_en`  output  1  enable for accumulator (capture acc + multiplicand)
- `shift_en`  output  1  enable for shift step of accumulator/multiplier
- `busy`  output  1  high in every state except IDLE
- `ready`  output  1  high only in IDLE
- `done`  output  1  one-cycle pulse, product valid at datapath output
- `iter`  output  $clog2(size+1)  completed shift count (debug)

## Operation
- States: IDLE, CLEAR, LOAD, TEST, ADD, SHIFT, DONE. Moore outputs decoded from state only.
- IDLE: `ready`=1. `start`=1 → CLEAR; else stay.
- CLEAR: `clear`=0 (only state where it is low) → LOAD.
- LOAD: `load_en`=1; `iter` ← 0 → TEST.
- TEST: no enables; `q0`=1 → ADD, `q0`=0 → SHIFT.
- ADD: `add_en`=1 → SHIFT.
- SHIFT: `shift_en`=1; `iter` ← `iter`+1; if `iter` == size-1 before increment → DONE, else → TEST.
- DONE: `done`=1 → IDLE unconditionally.
- At most one of `load_en`/`add_en`/`shift_en` high in any cycle; `clear` never low together with any enable.
- `start` outside IDLE: ignored, no queuing. `start` held high through DONE: IDLE is entered for one cycle (`ready`=1), then a new op begins.
- `q0` only sampled in TEST.
- `iter` saturates at `size`; holds value after DONE until next LOAD.

## Timing
- Reset (`reset`=1 at an edge): next cycle state=IDLE, `iter`=0, `clear`=1, `load_en`=`add_en`=`shift_en`=`done`=`busy`=0, `ready`=1. Overrides `start`.
- Reset mid-operation: same result next cycle; partial product abandoned; datapath is cleared by the next CLEAR.
- `start` sampled at edge k → CLEAR during cycle k+1, LOAD k+2, first TEST k+3.
- Each iteration: 2 cycles (TEST, SHIFT) if `q0`=0, 3 cycles (TEST, ADD, SHIFT) if `q0`=1.
- `done` high in cycle k+3+2·size+N, N = number of 1 bits in multiplier. `ready` again at the following cycle.
- size=8: min latency 19 cycles (multiplier 0x00), max 27 (0xFF).

## Test plan
- Reset: assert `reset` 2 cycles with `start`=1 → `ready`=1, `busy`=0, `clear`=1, all enables 0, `iter`=0; no CLEAR entered.
- size=8, multiplier 0x00, `start` pulse at edge k → `clear` low at k+1, `load_en` at k+2, 8 `shift_en` pulses, 0 `add_en`, `done` at k+19, `iter`=8.
- size=8, multiplier 0xFF (`q0` modelled from shifting datapath) → 8 `add_en` pulses each followed by `shift_en`, `done` at k+27; with real datapath 0xFF×0xFF = 0xFE01.
- size=8, 0x0D × 0x0B with full datapath → 3 adds, `done` at k+22, product 0x008F.
- `start` pulsed during TEST and during DONE → ignored, single `done`; `start` held high continuously → back-to-back ops separated by exactly one `ready` cycle.
- `reset` asserted while in ADD → IDLE next cycle, no `done`; following `start` completes normally with correct latency and product.

Source files
------------

// File: rtl/mult_if.sv
// mult_if
//   Bundles the control handshake between the multiplier sequencer and the
//   operand/accumulator datapath.
//   Ports (signals):
//     start    - request a multiplication (driven by requester)
//     q0       - current multiplier LSB (driven by datapath)
//     clear    - active-low clear to datapath registers
//     load_en  - operand register load enable
//     add_en   - accumulator capture enable
//     shift_en - accumulator/multiplier shift enable
//     busy     - sequencer is not idle
//     ready    - sequencer is idle
//     done     - one-cycle pulse, product valid
//     iter     - completed shift count (debug)
//   Modports:
//     master - requester/datapath side
//     slave  - sequencer side (mult_controller)
interface mult_if #(
   parameter int size = 8
);
   localparam int IW = $clog2(size + 1);

   logic          start;
   logic          q0;
   logic          clear;
   logic          load_en;
   logic          add_en;
   logic          shift_en;
   logic          busy;
   logic          ready;
   logic          done;
   logic [IW-1:0] iter;

   modport master (
      output start, q0,
      input  clear, load_en, add_en, shift_en, busy, ready, done, iter
   );

   modport slave (
      input  start, q0,
      output clear, load_en, add_en, shift_en, busy, ready, done, iter
   );
endinterface

// File: rtl/mult_controller.sv
// mult_controller
//   Sequencing FSM for a sum-and-shift multiplier datapath. On start it
//   clears and loads the datapath, runs `size` test/add/shift iterations
//   steered by the multiplier LSB, then pulses done for one cycle.
//   Ports:
//     clk   - clock, rising edge
//     reset - synchronous, active-high reset
//     bus   - mult_if.slave: start/q0 in; clear, load_en, add_en, shift_en,
//             busy, ready, done, iter out
//   All outputs are registered; each is decoded from the state the FSM is
//   about to enter, so the registered values line up with the state register.
module mult_controller #(
   parameter int size = 8
) (
   input  logic   clk,
   input  logic   reset,
   mult_if.slave  bus
);

   localparam int IW = $clog2(size + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CLEAR = 3'd1;
   localparam logic [2:0] LOAD  = 3'd2;
   localparam logic [2:0] TEST  = 3'd3;
   localparam logic [2:0] ADD   = 3'd4;
   localparam logic [2:0] SHIFT = 3'd5;
   localparam logic [2:0] DONE  = 3'd6;

   localparam logic [IW-1:0] ITER_LAST = IW'(size - 1);
   localparam logic [IW-1:0] ITER_MAX  = IW'(size);
   localparam logic [IW-1:0] ITER_ONE  = IW'(1);

   // Output vector order: {clear, load_en, add_en, shift_en, busy, ready, done}
   localparam logic [6:0] IDLE_OUT = 7'b1000010;

   logic [2:0]    state_r;
   logic [2:0]    next_s;
   logic [6:0]    out_r;
   logic [IW-1:0] iter_r;
   logic [IW-1:0] iter_next_s;

   // Moore output decode for a given state.
   function automatic logic [6:0] decode_outputs(input logic [2:0] st);
      logic [6:0] o;
      case (st)
         IDLE:    o = 7'b1000010;
         CLEAR:   o = 7'b0000100;
         LOAD:    o = 7'b1100100;
         TEST:    o = 7'b1000100;
         ADD:     o = 7'b1010100;
         SHIFT:   o = 7'b1001100;
         DONE:    o = 7'b1000101;
         default: o = IDLE_OUT;
      endcase
      return o;
   endfunction

   // Next-state selection; start only matters in IDLE, q0 only in TEST.
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               next_s = CLEAR;
            end else begin
               next_s = IDLE;
            end
         end
         CLEAR:   next_s = LOAD;
         LOAD:    next_s = TEST;
         TEST: begin
            if (bus.q0) begin
               next_s = ADD;
            end else begin
               next_s = SHIFT;
            end
         end
         ADD:     next_s = SHIFT;
         SHIFT: begin
            // Compare against the pre-increment count: the size-th shift ends the op.
            if (iter_r == ITER_LAST) begin
               next_s = DONE;
            end else begin
               next_s = TEST;
            end
         end
         DONE:    next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // Iteration counter update: cleared in LOAD, bumped (saturating) in SHIFT.
   always_comb begin
      iter_next_s = iter_r;
      case (state_r)
         LOAD: iter_next_s = '0;
         SHIFT: begin
            if (iter_r != ITER_MAX) begin
               iter_next_s = iter_r + ITER_ONE;
            end else begin
               iter_next_s = iter_r;
            end
         end
         default: iter_next_s = iter_r;
      endcase
   end

   // State, registered outputs and iteration counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         out_r   <= IDLE_OUT;
         iter_r  <= '0;
      end else begin
         state_r <= next_s;
         out_r   <= decode_outputs(next_s);
         iter_r  <= iter_next_s;
      end
   end

   assign bus.clear    = out_r[6];
   assign bus.load_en  = out_r[5];
   assign bus.add_en   = out_r[4];
   assign bus.shift_en = out_r[3];
   assign bus.busy     = out_r[2];
   assign bus.ready    = out_r[1];
   assign bus.done     = out_r[0];
   assign bus.iter     = iter_r;

endmodule

// File: tb/tb_mult_controller.sv
module tb_mult_controller;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mult_if #(.size(8)) bus();

   mult_controller #(.size(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [15:0] prod;
      int          done_cyc;
      int          adds;
   } exp_t;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] prod;
      int          lat;
      int          adds;
   } vec_t;

   exp_t sb[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   cyc       = 0;
   int   add_cnt   = 0;
   int   shift_cnt = 0;

   // Reference datapath: {carry, acc, b} product register, q0 = b[0]
   logic [7:0] mcand  = 8'd0;
   logic [7:0] mplier = 8'd0;
   logic [7:0] dp_a   = 8'd0;
   logic [7:0] dp_acc = 8'd0;
   logic [7:0] dp_b   = 8'd0;
   logic       dp_c   = 1'b0;

   assign bus.q0 = dp_b[0];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (!bus.clear) begin
         dp_c <= 1'b0; dp_acc <= 8'd0; dp_a <= 8'd0; dp_b <= 8'd0;
      end else if (bus.load_en) begin
         dp_a <= mcand; dp_b <= mplier;
      end else if (bus.add_en) begin
         {dp_c, dp_acc} <= {1'b0, dp_acc} + {1'b0, dp_a};
      end else if (bus.shift_en) begin
         {dp_c, dp_acc, dp_b} <= {1'b0, dp_c, dp_acc, dp_b[7:1]};
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Per-cycle invariants and scoreboard pop on done
   always @(negedge clk) begin
      if (cyc > 0 && !reset) begin
         check("enable_onehot", 32'($countones({bus.load_en, bus.add_en, bus.shift_en}) <= 1), 32'd1);
         check("clear_with_enable", 32'(!bus.clear && (bus.load_en || bus.add_en || bus.shift_en)), 32'd0);
         check("busy_xor_ready", 32'(bus.busy ^ bus.ready), 32'd1);
         if (bus.load_en) begin
            add_cnt = 0; shift_cnt = 0;
         end
         add_cnt   += int'(bus.add_en);
         shift_cnt += int'(bus.shift_en);
         if (bus.done) begin
            if (sb.size() == 0) begin
               check("spurious_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("done_cycle", 32'(cyc), 32'(e.done_cyc));
               check("product", {16'd0, dp_acc, dp_b}, {16'd0, e.prod});
               check("iter_at_done", 32'(bus.iter), 32'd8);
               check("add_count", 32'(add_cnt), 32'(e.adds));
               check("shift_count", 32'(shift_cnt), 32'd8);
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!bus.ready && n < 100) begin
         @(negedge clk); n++;
      end
      if (!bus.ready) check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_sb_empty();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk); n++;
      end
      if (sb.size() != 0) begin
         check("done_timeout", 32'd0, 32'd1);
         sb.delete();
      end
   endtask

   // Start one op at a negedge; done expected lat-1 negedges after the CLEAR cycle
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] prod, input int lat, input int adds);
      int s;
      wait_idle();
      mcand = a; mplier = b; bus.start = 1'b1;
      @(negedge clk);
      s = cyc;
      bus.start = 1'b0;
      check("clear_low_k1", 32'(bus.clear), 32'd0);
      sb.push_back('{prod, s + lat - 1, adds});
      @(negedge clk);
      check("load_en_k2", 32'(bus.load_en), 32'd1);
      wait_sb_empty();
   endtask

   vec_t vecs[6];

   initial begin
      int s;
      int n;
      bit pulsed_test;
      bit pulsed_done;

      vecs[0] = '{8'h5A, 8'h00, 16'h0000, 19, 0};
      vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 27, 8};
      vecs[2] = '{8'h0D, 8'h0B, 16'h008F, 22, 3};
      vecs[3] = '{8'h80, 8'h01, 16'h0080, 20, 1};
      vecs[4] = '{8'h12, 8'h34, 16'h03A8, 22, 3};
      vecs[5] = '{8'h01, 8'h80, 16'h0080, 20, 1};

      // Reset held two cycles with start high: must stay idle
      reset = 1'b1; bus.start = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_ready", 32'(bus.ready), 32'd1);
         check("rst_busy", 32'(bus.busy), 32'd0);
         check("rst_clear", 32'(bus.clear), 32'd1);
         check("rst_enables", {29'd0, bus.load_en, bus.add_en, bus.shift_en}, 32'd0);
         check("rst_done", 32'(bus.done), 32'd0);
         check("rst_iter", 32'(bus.iter), 32'd0);
      end
      reset = 1'b0; bus.start = 1'b0;
      @(negedge clk);
      check("post_rst_clear", 32'(bus.clear), 32'd1);
      check("post_rst_ready", 32'(bus.ready), 32'd1);

      // Table-driven operations
      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat, vecs[i].adds);
      end

      // start pulsed in TEST and in DONE: ignored, exactly one done
      wait_idle();
      mcand = 8'h0D; mplier = 8'h0B; bus.start = 1'b1;
      @(negedge clk);
      s = cyc; bus.start = 1'b0;
      sb.push_back('{16'h008F, s + 21, 3});
      pulsed_test = 1'b0; pulsed_done = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (bus.busy && bus.clear && !bus.load_en && !bus.add_en && !bus.shift_en
             && !bus.done && !pulsed_test) begin
            bus.start = 1'b1; pulsed_test = 1'b1;
         end else if (bus.done && !pulsed_done) begin
            bus.start = 1'b1; pulsed_done = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      check("ignored_start_queue", 32'(sb.size()), 32'd0);
      check("ignored_start_ready", 32'(bus.ready), 32'd1);
      check("ignored_start_clear", 32'(bus.clear), 32'd1);
      check("pulsed_both", {30'd0, pulsed_test, pulsed_done}, 32'd3);

      // start held high: back-to-back ops with exactly one ready cycle between
      wait_idle();
      mcand = 8'h0D; mplier = 8'h0B; bus.start = 1'b1;
      @(negedge clk);
      s = cyc;
      sb.push_back('{16'h008F, s + 21, 3});
      n = 0;
      while (!bus.done && n < 60) begin
         @(negedge clk); n++;
      end
      check("held_first_done", 32'(bus.done), 32'd1);
      @(negedge clk);
      check("held_gap_ready", 32'(bus.ready), 32'd1);
      check("held_gap_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("held_second_clear", 32'(bus.clear), 32'd0);
      sb.push_back('{16'h008F, cyc + 21, 3});
      bus.start = 1'b0;
      wait_sb_empty();

      // Reset during ADD: idle next cycle, no done, then a clean op
      wait_idle();
      mcand = 8'hFF; mplier = 8'hFF; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (!bus.add_en && n < 20) begin
         @(negedge clk); n++;
      end
      check("reached_add", 32'(bus.add_en), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_ready", 32'(bus.ready), 32'd1);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      check("midrst_iter", 32'(bus.iter), 32'd0);
      check("midrst_clear", 32'(bus.clear), 32'd1);
      repeat (30) @(negedge clk);
      check("midrst_still_idle", 32'(bus.ready), 32'd1);
      run_op(8'h0D, 8'h0B, 16'h008F, 22, 3);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
